// File: rtl/ppu_pkg.sv
// ============================================================================
// Module      : ppu_pkg
// Description : Shared PPU fetcher state codes, VRAM bases, attribute layout
//               and the bitplane-to-pixel row helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ppu_pkg;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t c_st_idle      = 3'd0;
  localparam fetch_state_t c_st_tile_num  = 3'd1;
  localparam fetch_state_t c_st_attr      = 3'd2;
  localparam fetch_state_t c_st_data_low  = 3'd3;
  localparam fetch_state_t c_st_data_high = 3'd4;
  localparam fetch_state_t c_st_push      = 3'd5;
  localparam fetch_state_t c_st_pause     = 3'd6;

  localparam logic [15:0] c_map_base_lo      = 16'h9800;
  localparam logic [15:0] c_map_base_hi      = 16'h9C00;
  localparam logic [15:0] c_tile_base_8000   = 16'h8000;
  localparam logic [15:0] c_tile_base_9000   = 16'h9000;

  localparam int c_attr_pal_lsb   = 0;
  localparam int c_attr_bank_bit  = 3;
  localparam int c_attr_xflip_bit = 5;
  localparam int c_attr_yflip_bit = 6;
  localparam int c_attr_prio_bit  = 7;

  typedef struct packed {
    logic       prio;
    logic       yflip;
    logic       xflip;
    logic       bank;
    logic [2:0] pal;
  } bg_attr_t;

  // Pixel i occupies bits [2i+1:2i]; index 0 is the leftmost pixel.
  function automatic logic [15:0] assemble_row(input logic [7:0] lo,
                                               input logic [7:0] hi,
                                               input logic       xflip);
    logic [15:0] row;
    row = '0;
    for (int i = 0; i < 8; i++) begin
      row[2*i +: 2] = xflip ? {hi[i], lo[i]} : {hi[7-i], lo[7-i]};
    end
    return row;
  endfunction

endpackage

`default_nettype wire

// File: rtl/EvtCounter.sv
// ============================================================================
// Module      : EvtCounter
// Description : Event counter with synchronous clear, wrapping at MAX_COUNT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module EvtCounter #(
  parameter int MAX_COUNT = 32
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         clr_in,
  input  logic                         evt_in,
  output logic [$clog2(MAX_COUNT)-1:0] count_out
);

  localparam int c_w = $clog2(MAX_COUNT);
  localparam logic [c_w-1:0] c_last = c_w'(MAX_COUNT - 1);

  logic [c_w-1:0] r_count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_count <= '0;
    end else if (clr_in) begin
      r_count <= '0;
    end else if (evt_in) begin
      r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
    end
  end

  assign count_out = r_count;

endmodule

`default_nettype wire

// File: rtl/tile_addr_gen.sv
// ============================================================================
// Module      : tile_addr_gen
// Description : Combinational tile-map and tile-data address generation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_addr_gen
  import ppu_pkg::*;
(
  input  logic        window_mode_in,
  input  logic        bg_map_in,
  input  logic        win_map_in,
  input  logic        addressing_mode_in,
  input  logic [4:0]  scx_tile_in,
  input  logic [7:0]  scy_in,
  input  logic [7:0]  ly_in,
  input  logic [4:0]  fetch_x_in,
  input  logic [4:0]  win_x_in,
  input  logic [7:0]  win_line_in,
  input  logic [7:0]  tile_in,
  input  logic        yflip_in,
  output logic [15:0] map_addr_out,
  output logic [15:0] data_addr_out
);

  logic [7:0]  w_y;
  logic [4:0]  w_x;
  logic [15:0] w_map_base;
  logic [2:0]  w_row;
  logic [15:0] w_tile_base;
  logic [15:0] w_tile_off;

  assign w_y        = window_mode_in ? win_line_in : scy_in + ly_in;
  assign w_x        = window_mode_in ? win_x_in : scx_tile_in + fetch_x_in;
  assign w_map_base = (window_mode_in ? win_map_in : bg_map_in) ? c_map_base_hi : c_map_base_lo;
  assign map_addr_out = w_map_base + {6'd0, w_y[7:3], w_x};

  assign w_row       = w_y[2:0] ^ {3{yflip_in}};
  assign w_tile_base = addressing_mode_in ? c_tile_base_8000 : c_tile_base_9000;
  // 0x9000 mode treats the tile number as signed; sign-extend tile*16 to 16 bits.
  assign w_tile_off  = addressing_mode_in ? {4'd0, tile_in, 4'd0}
                                          : {{4{tile_in[7]}}, tile_in, 4'd0};
  assign data_addr_out = w_tile_base + w_tile_off + {12'd0, w_row, 1'b0};

endmodule

`default_nettype wire

// File: rtl/cgb_tile_fetcher.sv
// ============================================================================
// Module      : cgb_tile_fetcher
// Description : BG/window tile fetcher with CGB attributes feeding the BG FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cgb_tile_fetcher
  import ppu_pkg::*;
#(
  parameter int         X_MAX           = 160,
  parameter int         TOTAL_SCANLINES = 154,
  parameter int         CGB_MODE        = 1,
  parameter logic [7:0] DATA_DEFAULT    = 8'hFF
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               tclk_in,
  input  logic                               line_start_in,
  input  logic                               window_start_in,
  input  logic                               frame_start_in,
  input  logic [$clog2(TOTAL_SCANLINES)-1:0] Y_in,
  input  logic [7:0]                         SCX_in,
  input  logic [7:0]                         SCY_in,
  input  logic                               bg_map_in,
  input  logic                               win_map_in,
  input  logic                               addressing_mode_in,
  output logic [15:0]                        addr_out,
  output logic                               bank_out,
  output logic                               addr_valid_out,
  input  logic [7:0]                         data_in,
  input  logic                               data_valid_in,
  output logic                               mem_busy_out,
  input  logic                               bg_fifo_empty_in,
  input  logic                               sprite_hit_in,
  output logic                               valid_pixels_out,
  output logic [15:0]                        pixels_out,
  output logic [2:0]                         palette_out,
  output logic                               priority_out
);

  if (X_MAX < 8 || X_MAX > 256) begin : g_xmax_check
    $error("cgb_tile_fetcher: X_MAX out of range");
  end

  fetch_state_t r_state;
  logic         r_phase;
  logic         r_window;
  logic         r_win_used;
  logic [7:0]   r_win_line;
  logic [7:0]   r_tile;
  logic [7:0]   r_low;
  logic [7:0]   r_high;
  bg_attr_t     r_attr;

  logic [4:0]   w_fetch_x;
  logic [4:0]   w_win_x;
  logic [15:0]  w_map_addr;
  logic [15:0]  w_data_addr;
  logic [7:0]   w_data;
  logic [7:0]   w_ly;
  bg_attr_t     w_attr_in;
  logic         w_line;
  logic         w_win;
  logic         w_push;
  logic [7:0]   w_push_high;
  logic         w_unused_scx_fine;

  assign w_unused_scx_fine = ^SCX_in[2:0];
  assign w_ly   = 8'(Y_in);
  assign w_data = data_valid_in ? data_in : DATA_DEFAULT;

  assign w_attr_in.prio  = w_data[c_attr_prio_bit];
  assign w_attr_in.yflip = w_data[c_attr_yflip_bit];
  assign w_attr_in.xflip = w_data[c_attr_xflip_bit];
  assign w_attr_in.bank  = w_data[c_attr_bank_bit];
  assign w_attr_in.pal   = w_data[c_attr_pal_lsb +: 3];

  // Event qualification in priority order: line start, window start, push.
  assign w_line = tclk_in & line_start_in;
  assign w_win  = tclk_in & ~line_start_in & window_start_in & (r_state != c_st_idle);
  assign w_push = tclk_in & ~line_start_in & ~w_win & bg_fifo_empty_in &
                  (((r_state == c_st_data_high) & r_phase) | (r_state == c_st_push));
  assign w_push_high = (r_state == c_st_data_high) ? w_data : r_high;

  EvtCounter #(.MAX_COUNT(32)) u_fetch_x (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clr_in   (w_line),
    .evt_in   (w_push),
    .count_out(w_fetch_x)
  );

  EvtCounter #(.MAX_COUNT(32)) u_win_x (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clr_in   (w_line | w_win),
    .evt_in   (w_push & r_window),
    .count_out(w_win_x)
  );

  tile_addr_gen u_addr (
    .window_mode_in    (r_window),
    .bg_map_in         (bg_map_in),
    .win_map_in        (win_map_in),
    .addressing_mode_in(addressing_mode_in),
    .scx_tile_in       (SCX_in[7:3]),
    .scy_in            (SCY_in),
    .ly_in             (w_ly),
    .fetch_x_in        (w_fetch_x),
    .win_x_in          (w_win_x),
    .win_line_in       (r_win_line),
    .tile_in           (r_tile),
    .yflip_in          (r_attr.yflip),
    .map_addr_out      (w_map_addr),
    .data_addr_out     (w_data_addr)
  );

  always_comb begin
    addr_out       = '0;
    bank_out       = 1'b0;
    addr_valid_out = 1'b0;
    case (r_state)
      c_st_tile_num: begin
        addr_out       = w_map_addr;
        addr_valid_out = ~r_phase;
      end
      c_st_attr: begin
        addr_out       = w_map_addr;
        bank_out       = 1'b1;
        addr_valid_out = ~r_phase;
      end
      c_st_data_low: begin
        addr_out       = w_data_addr;
        bank_out       = r_attr.bank;
        addr_valid_out = ~r_phase;
      end
      c_st_data_high: begin
        addr_out       = w_data_addr + 16'd1;
        bank_out       = r_attr.bank;
        addr_valid_out = ~r_phase;
      end
      default: ;
    endcase
  end

  assign mem_busy_out = (r_state != c_st_idle) && (r_state != c_st_pause);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state          <= c_st_idle;
      r_phase          <= 1'b0;
      r_window         <= 1'b0;
      r_win_used       <= 1'b0;
      r_win_line       <= '0;
      r_tile           <= '0;
      r_low            <= '0;
      r_high           <= '0;
      r_attr           <= '0;
      valid_pixels_out <= 1'b0;
      pixels_out       <= '0;
      palette_out      <= '0;
      priority_out     <= 1'b0;
    end else if (tclk_in) begin
      valid_pixels_out <= 1'b0;
      if (w_line) begin
        r_state    <= c_st_tile_num;
        r_phase    <= 1'b0;
        r_window   <= 1'b0;
        r_win_used <= 1'b0;
        if (r_win_used) begin
          r_win_line <= r_win_line + 8'd1;
        end
      end else if (w_win) begin
        r_state    <= c_st_tile_num;
        r_phase    <= 1'b0;
        r_window   <= 1'b1;
        r_win_used <= 1'b1;
      end else if (w_push) begin
        valid_pixels_out <= 1'b1;
        pixels_out       <= assemble_row(r_low, w_push_high, r_attr.xflip);
        palette_out      <= r_attr.pal;
        priority_out     <= r_attr.prio;
        r_high           <= w_push_high;
        r_phase          <= 1'b0;
        r_state          <= sprite_hit_in ? c_st_pause : c_st_tile_num;
      end else begin
        case (r_state)
          c_st_tile_num, c_st_attr, c_st_data_low, c_st_data_high: begin
            r_phase <= ~r_phase;
            if (r_phase) begin
              case (r_state)
                c_st_tile_num: begin
                  r_tile  <= w_data;
                  r_state <= (CGB_MODE != 0) ? c_st_attr : c_st_data_low;
                end
                c_st_attr: begin
                  r_attr  <= w_attr_in;
                  r_state <= c_st_data_low;
                end
                c_st_data_low: begin
                  r_low   <= w_data;
                  r_state <= c_st_data_high;
                end
                default: begin
                  r_high  <= w_data;
                  r_state <= c_st_push;
                end
              endcase
            end
          end
          c_st_pause: begin
            if (!sprite_hit_in) begin
              r_state <= c_st_tile_num;
              r_phase <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      // A frame boundary restarts window line counting from row 0.
      if (frame_start_in) begin
        r_win_line <= '0;
        if (!w_line && !w_win) begin
          r_win_used <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cgb_tile_fetcher.sv
// ============================================================================
// Module      : tb_cgb_tile_fetcher
// Description : Directed self-checking bench for cgb_tile_fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cgb_tile_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        tclk_in = 1'b0;
  logic        line_start_in = 1'b0;
  logic        window_start_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic [7:0]  Y_in = 8'd0;
  logic [7:0]  SCX_in = 8'd0;
  logic [7:0]  SCY_in = 8'd0;
  logic        bg_map_in = 1'b0;
  logic        win_map_in = 1'b1;
  logic        addressing_mode_in = 1'b1;
  logic [15:0] addr_out;
  logic        bank_out;
  logic        addr_valid_out;
  logic [7:0]  data_in;
  logic        data_valid_in = 1'b1;
  logic        mem_busy_out;
  logic        bg_fifo_empty_in = 1'b1;
  logic        sprite_hit_in = 1'b0;
  logic        valid_pixels_out;
  logic [15:0] pixels_out;
  logic [2:0]  palette_out;
  logic        priority_out;

  logic [7:0] vram0 [0:8191];
  logic [7:0] vram1 [0:8191];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  assign data_in = bank_out ? vram1[addr_out[12:0]] : vram0[addr_out[12:0]];

  cgb_tile_fetcher #(
    .X_MAX          (160),
    .TOTAL_SCANLINES(154),
    .CGB_MODE       (1),
    .DATA_DEFAULT   (8'hFF)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .tclk_in           (tclk_in),
    .line_start_in     (line_start_in),
    .window_start_in   (window_start_in),
    .frame_start_in    (frame_start_in),
    .Y_in              (Y_in),
    .SCX_in            (SCX_in),
    .SCY_in            (SCY_in),
    .bg_map_in         (bg_map_in),
    .win_map_in        (win_map_in),
    .addressing_mode_in(addressing_mode_in),
    .addr_out          (addr_out),
    .bank_out          (bank_out),
    .addr_valid_out    (addr_valid_out),
    .data_in           (data_in),
    .data_valid_in     (data_valid_in),
    .mem_busy_out      (mem_busy_out),
    .bg_fifo_empty_in  (bg_fifo_empty_in),
    .sprite_hit_in     (sprite_hit_in),
    .valid_pixels_out  (valid_pixels_out),
    .pixels_out        (pixels_out),
    .palette_out       (palette_out),
    .priority_out      (priority_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One T-cycle: tclk high for one clk edge, low for the next.
  task automatic tc();
    tclk_in = 1'b1;
    @(posedge clk_in); #1;
    tclk_in = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic pulse_line();
    line_start_in = 1'b1; tc(); line_start_in = 1'b0;
  endtask

  task automatic pulse_win();
    window_start_in = 1'b1; tc(); window_start_in = 1'b0;
  endtask

  // Expects to be called right after entry into TILE_NUM with the FIFO empty.
  task automatic step_row(input string tag, input logic [15:0] map_a, input logic [15:0] data_a,
                          input logic dbank, input logic [15:0] pix, input logic [2:0] pal,
                          input logic pri);
    logic [15:0] hi_a;
    hi_a = data_a + 16'd1;
    chk({tag, ".map"}, {mem_busy_out, bank_out, addr_valid_out, addr_out}, {1'b1, 1'b0, 1'b1, map_a});
    tc(); chk({tag, ".ph1"}, addr_valid_out, 32'd0);
    tc(); chk({tag, ".attr"}, {bank_out, addr_valid_out, addr_out}, {1'b1, 1'b1, map_a});
    tc(); tc(); chk({tag, ".lo"}, {bank_out, addr_valid_out, addr_out}, {dbank, 1'b1, data_a});
    tc(); tc(); chk({tag, ".hi"}, {bank_out, addr_valid_out, addr_out}, {dbank, 1'b1, hi_a});
    tc(); chk({tag, ".early"}, valid_pixels_out, 32'd0);
    tc(); chk({tag, ".push"}, {valid_pixels_out, priority_out, palette_out, pixels_out},
              {1'b1, pri, pal, pix});
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      vram0[i] = 8'h00;
      vram1[i] = 8'h00;
    end
    vram0[13'h1800] = 8'h01;
    vram0[13'h0010] = 8'hF0;
    vram0[13'h0011] = 8'hCC;

    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    chk("reset", {valid_pixels_out, addr_valid_out, mem_busy_out, bank_out, palette_out,
                  priority_out, pixels_out, addr_out}, 32'd0);
    tc(); pulse_win(); tc();
    chk("idle_hold", {mem_busy_out, addr_valid_out, valid_pixels_out}, 32'd0);

    // Plain BG tile 1, unsigned addressing.
    pulse_line();
    step_row("bg", 16'h9800, 16'h8010, 1'b0, 16'h0A5F, 3'd0, 1'b0);
    tc(); chk("hold", {valid_pixels_out, pixels_out}, {1'b0, 16'h0A5F});

    // Attribute: bank 1, x/y flip, palette 5.
    vram1[13'h1800] = 8'h6D;
    vram1[13'h001E] = 8'hF0;
    vram1[13'h001F] = 8'hCC;
    pulse_line();
    step_row("attr", 16'h9800, 16'h801E, 1'b1, 16'hF5A0, 3'd5, 1'b0);

    // Signed addressing, tile 0x80, priority bit.
    addressing_mode_in = 1'b0;
    vram0[13'h1800] = 8'h80;
    vram1[13'h1800] = 8'h80;
    vram0[13'h0800] = 8'hAA;
    vram0[13'h0801] = 8'h55;
    pulse_line();
    step_row("signed", 16'h9800, 16'h8800, 1'b0, 16'h9999, 3'd0, 1'b1);

    // Map X wrap from 31 to 0.
    addressing_mode_in = 1'b1;
    SCX_in = 8'hF8;
    vram0[13'h181F] = 8'h02;
    vram0[13'h0020] = 8'hFF;
    vram0[13'h0021] = 8'h00;
    pulse_line();
    step_row("wrap31", 16'h981F, 16'h8020, 1'b0, 16'h5555, 3'd0, 1'b0);
    step_row("wrap0", 16'h9800, 16'h8800, 1'b0, 16'h9999, 3'd0, 1'b1);

    // Invalid data substitutes 0xFF everywhere.
    SCX_in = 8'h00;
    data_valid_in = 1'b0;
    pulse_line();
    step_row("dflt", 16'h9800, 16'h8FFE, 1'b1, 16'hFFFF, 3'd7, 1'b1);
    data_valid_in = 1'b1;

    // FIFO backpressure then sprite pause.
    pulse_line();
    repeat (7) tc();
    bg_fifo_empty_in = 1'b0;
    tc();
    chk("bp_enter", {valid_pixels_out, addr_valid_out, mem_busy_out}, {1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      tc(); chk("bp_wait", valid_pixels_out, 32'd0);
    end
    bg_fifo_empty_in = 1'b1;
    sprite_hit_in = 1'b1;
    tc();
    chk("bp_push", {valid_pixels_out, mem_busy_out, pixels_out}, {1'b1, 1'b0, 16'h9999});
    tc();
    chk("pause", {valid_pixels_out, mem_busy_out, addr_valid_out}, 32'd0);
    sprite_hit_in = 1'b0;
    tc();
    chk("resume", {mem_busy_out, addr_valid_out, bank_out, addr_out}, {1'b1, 1'b1, 1'b0, 16'h9801});

    // Window start during DATA_LOW aborts the BG fetch.
    vram0[13'h1C00] = 8'h03;
    vram0[13'h0030] = 8'h0F;
    vram0[13'h0031] = 8'hF0;
    vram0[13'h0032] = 8'h33;
    vram0[13'h0033] = 8'hCC;
    pulse_line();
    repeat (4) tc();
    chk("bg_lo", {bank_out, addr_valid_out, addr_out}, {1'b0, 1'b1, 16'h8800});
    pulse_win();
    chk("win_abort", {valid_pixels_out, addr_valid_out, addr_out}, {1'b0, 1'b1, 16'h9C00});
    step_row("win0", 16'h9C00, 16'h8030, 1'b0, 16'h55AA, 3'd0, 1'b0);
    pulse_line();
    pulse_win();
    step_row("win1", 16'h9C00, 16'h8032, 1'b0, 16'h5A5A, 3'd0, 1'b0);
    frame_start_in = 1'b1; tc(); frame_start_in = 1'b0;
    pulse_line();
    pulse_win();
    step_row("winf", 16'h9C00, 16'h8030, 1'b0, 16'h55AA, 3'd0, 1'b0);

    // Asynchronous reset mid-fetch.
    pulse_line();
    repeat (6) tc();
    chk("pre_rst", addr_valid_out, 32'd1);
    #2 rst_in = 1'b1;
    #1;
    chk("async_rst", {valid_pixels_out, addr_valid_out, mem_busy_out, bank_out, palette_out,
                      priority_out, pixels_out, addr_out}, 32'd0);
    @(posedge clk_in); #1 rst_in = 1'b0;
    repeat (3) tc();
    chk("post_rst", {valid_pixels_out, mem_busy_out, addr_valid_out}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
